// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-lookahead adder/subtractor with a valid/ready handshake.
// Stage 1 registers bit and group propagate/generate; stage 2 resolves carries and the result.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int NG = (WIDTH + GROUP - 1) / GROUP;

  logic             s1_valid;
  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] g_d;
  logic [NG-1:0]    gg_d;
  logic [NG-1:0]    gp_d;

  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] g_q;
  logic [NG-1:0]    gg_q;
  logic [NG-1:0]    gp_q;
  logic             c0_q;

  logic [NG:0]      gc;
  logic [WIDTH-1:0] c;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Group terms span only the real bits, so the last group's carry-out is the carry out of bit WIDTH-1.
  always_comb begin
    b_eff = b ^ {WIDTH{sub}};
    p_d   = a ^ b_eff;
    g_d   = a & b_eff;
    gg_d  = '0;
    gp_d  = '1;
    for (int i = 0; i < WIDTH; i++) begin
      gg_d[i / GROUP] = g_d[i] | (p_d[i] & gg_d[i / GROUP]);
      gp_d[i / GROUP] = gp_d[i / GROUP] & p_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: datapath registers have no reset; the valid bit alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      p_q  <= p_d;
      g_q  <= g_d;
      gg_q <= gg_d;
      gp_q <= gp_d;
      c0_q <= sub | cin;
    end
  end

  // Sum-of-products lookahead: a carry is any lower generate whose path up to here fully propagates.
  always_comb begin
    logic acc;
    logic pp;
    gc = '0;
    c  = '0;
    for (int k = 0; k <= NG; k++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int m = k - 1; m >= 0; m--) begin
        acc = acc | (pp & gg_q[m]);
        pp  = pp & gp_q[m];
      end
      gc[k] = acc | (pp & c0_q);
    end
    for (int i = 0; i < WIDTH; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int m = i - 1; m >= (i / GROUP) * GROUP; m--) begin
        acc = acc | (pp & g_q[m]);
        pp  = pp & p_q[m];
      end
      c[i] = acc | (pp & gc[i / GROUP]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        s    <= p_q ^ c;
        cout <= gc[NG];
        ovf  <= c[WIDTH-1] ^ gc[NG];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed vectors on 16- and 11-bit instances plus
// randomized streams with random back-pressure on four width/group variants.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [63:0] s;
  } res_t;

  localparam int N_RAND = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic res_t pack(input logic ovf, input logic cout, input logic [63:0] s);
    res_t r;
    r.ovf  = ovf;
    r.cout = cout;
    r.s    = s;
    return r;
  endfunction

  // Reference: plain (w+1)-bit arithmetic, overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bb;
    logic [64:0] full;
    res_t        r;
    mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    am     = a & mask;
    bb     = (sub ? ~b : b) & mask;
    full   = {1'b0, am} + {1'b0, bb} + 65'(sub ? 1'b1 : cin);
    r.s    = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = (am[w-1] == bb[w-1]) && (r.s[w-1] != am[w-1]);
    return r;
  endfunction

  // ---------------- 16-bit directed instance ----------------
  logic        d_rst, d_in_valid, d_in_ready, d_cin, d_sub, d_out_valid, d_out_ready, d_cout, d_ovf;
  logic [15:0] d_a, d_b, d_s;
  res_t        dq[$];
  logic        d_held = 1'b0;
  res_t        d_held_v;
  res_t        d_cur;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .s(d_s), .cout(d_cout), .ovf(d_ovf)
  );

  // Compare process for the directed instance: ordering, hold-while-stalled, no spurious results.
  always @(negedge clk) begin
    #2;
    d_cur = pack(d_ovf, d_cout, 64'(d_s));
    if (d_rst) begin
      dq.delete();
      d_held = 1'b0;
    end else begin
      if (d_held) begin
        check("d16_hold_valid", 66'(d_out_valid), 66'(1));
        check("d16_hold_data", d_cur, d_held_v);
      end
      d_held   = d_out_valid && !d_out_ready;
      d_held_v = d_cur;
      if (d_out_valid && d_out_ready) begin
        if (dq.size() == 0) check("d16_spurious_out", 66'(d_out_valid), 66'(0));
        else check("d16_result", d_cur, dq.pop_front());
      end
      if (d_in_valid && d_in_ready) dq.push_back(model(16, 64'(d_a), 64'(d_b), d_cin, d_sub));
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    d_a = a; d_b = b; d_cin = cin; d_sub = sub; d_in_valid = 1'b1;
    for (int t = 0; t < 16; t++) begin
      #1;
      if (d_in_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("d16_send_timeout", 66'(d_in_ready), 66'(1));
  endtask

  task automatic op_literal(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub,
                            input logic [15:0] es, input logic ec, input logic eo);
    send(a, b, cin, sub);
    d_in_valid = 1'b0;
    #1 check({name, "_lat1_valid"}, 66'(d_out_valid), 66'(0));
    @(negedge clk);
    #1;
    check({name, "_lat2_valid"}, 66'(d_out_valid), 66'(1));
    check({name, "_s"}, 66'(d_s), 66'(es));
    check({name, "_cout"}, 66'(d_cout), 66'(ec));
    check({name, "_ovf"}, 66'(d_ovf), 66'(eo));
    @(negedge clk);
  endtask

  // ---------------- 11-bit partial-group instance ----------------
  logic        e_in_valid, e_in_ready, e_cin, e_sub, e_out_valid, e_out_ready, e_cout, e_ovf;
  logic [10:0] e_a, e_b, e_s;
  logic        rst_g;

  pipelined_cla_adder #(.WIDTH(11), .GROUP(4)) u_dut11 (
    .clk(clk), .rst(rst_g), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .a(e_a), .b(e_b), .cin(e_cin), .sub(e_sub),
    .out_valid(e_out_valid), .out_ready(e_out_ready),
    .s(e_s), .cout(e_cout), .ovf(e_ovf)
  );

  initial begin
    rst_g = 1'b1;
    repeat (3) @(negedge clk);
    rst_g = 1'b0;
  end

  // ---------------- randomized instances ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_rand
    localparam int W = (gi == 0) ? 2 : (gi == 1) ? 11 : (gi == 2) ? 16 : 33;
    localparam int G = (gi == 0) ? 2 : (gi == 1) ? 4 : (gi == 2) ? 3 : 8;

    logic         r_in_valid, r_in_ready, r_cin, r_sub, r_out_valid, r_out_ready, r_cout, r_ovf;
    logic [W-1:0] r_a, r_b, r_s;
    logic         done = 1'b0;
    res_t         q[$];

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) u_dut (
      .clk(clk), .rst(rst_g), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .a(r_a), .b(r_b), .cin(r_cin), .sub(r_sub),
      .out_valid(r_out_valid), .out_ready(r_out_ready),
      .s(r_s), .cout(r_cout), .ovf(r_ovf)
    );

    initial begin : drive
      int   accepted;
      int   cyc;
      logic held;
      res_t held_v;
      res_t cur;
      accepted = 0; cyc = 0; held = 1'b0;
      r_in_valid = 1'b0; r_out_ready = 1'b0;
      r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0;
      @(negedge clk);
      while (rst_g) @(negedge clk);
      while ((accepted < N_RAND || q.size() != 0) && cyc < 40000) begin
        cyc++;
        r_out_ready = ($urandom_range(0, 3) != 0);
        if (accepted < N_RAND) begin
          r_in_valid = ($urandom_range(0, 3) != 0);
          r_a   = W'({$urandom(), $urandom()});
          r_b   = W'({$urandom(), $urandom()});
          r_cin = 1'($urandom_range(0, 1));
          r_sub = 1'($urandom_range(0, 1));
        end else begin
          r_in_valid = 1'b0;
        end
        #1;
        cur = pack(r_ovf, r_cout, 64'(r_s));
        if (held) begin
          check($sformatf("w%0d_hold_valid", W), 66'(r_out_valid), 66'(1));
          check($sformatf("w%0d_hold_data", W), cur, held_v);
        end
        held   = r_out_valid && !r_out_ready;
        held_v = cur;
        if (r_out_valid && r_out_ready) begin
          if (q.size() == 0) check($sformatf("w%0d_spurious_out", W), 66'(r_out_valid), 66'(0));
          else check($sformatf("w%0d_result", W), cur, q.pop_front());
        end
        if (r_in_valid && r_in_ready) begin
          q.push_back(model(W, 64'(r_a), 64'(r_b), r_cin, r_sub));
          accepted++;
          check($sformatf("w%0d_in_flight", W), 66'(q.size() <= 2), 66'(1));
        end
        @(negedge clk);
      end
      check($sformatf("w%0d_accepted", W), 66'(accepted), 66'(N_RAND));
      check($sformatf("w%0d_drained", W), 66'(q.size()), 66'(0));
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic all_done;
    d_rst = 1'b1; d_in_valid = 1'b1; d_a = 16'h0003; d_b = 16'h0004;
    d_cin = 1'b0; d_sub = 1'b0; d_out_ready = 1'b1;
    e_in_valid = 1'b0; e_out_ready = 1'b1; e_a = '0; e_b = '0; e_cin = 1'b0; e_sub = 1'b0;

    // Reset with an operand offered: nothing may emerge.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 66'(d_out_valid), 66'(0));
    check("rst_s", 66'(d_s), 66'(0));
    check("rst_cout", 66'(d_cout), 66'(0));
    check("rst_ovf", 66'(d_ovf), 66'(0));
    d_rst = 1'b0;
    d_in_valid = 1'b0;
    #1 check("in_ready_after_rst", 66'(d_in_ready), 66'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("rst_op_discarded", 66'(d_out_valid), 66'(0));
    end
    @(negedge clk);

    op_literal("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op_literal("7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op_literal("5_minus_7",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op_literal("8000_minus_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back stream with the output stalled after the first result.
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    send(16'hF000, 16'h0F00, 1'b1, 1'b1);
    d_out_ready = 1'b0;
    d_a = 16'h8000; d_b = 16'h8000; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 66'(d_in_ready), 66'(0));
      check("stall_out_valid", 66'(d_out_valid), 66'(1));
      check("stall_s", 66'(d_s), 66'(16'h2345));
      @(negedge clk);
    end
    d_out_ready = 1'b1;
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    d_in_valid = 1'b0;
    for (int t = 0; t < 20 && dq.size() != 0; t++) @(negedge clk);
    check("stream_drained", 66'(dq.size()), 66'(0));
    @(negedge clk);

    // Reset with two operations in flight.
    send(16'h0101, 16'h0202, 1'b0, 1'b0);
    send(16'h0303, 16'h0404, 1'b0, 1'b0);
    d_in_valid = 1'b0;
    d_rst = 1'b1;
    @(negedge clk);
    d_rst = 1'b0;
    #1;
    check("midrst_in_ready", 66'(d_in_ready), 66'(1));
    check("midrst_out_valid", 66'(d_out_valid), 66'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("midrst_no_pulse", 66'(d_out_valid), 66'(0));
    end
    @(negedge clk);

    // Partial last group on the 11-bit instance.
    e_a = 11'h7FF; e_b = 11'h001; e_cin = 1'b1; e_sub = 1'b0; e_in_valid = 1'b1;
    #1 check("w11_in_ready", 66'(e_in_ready), 66'(1));
    @(negedge clk);
    e_in_valid = 1'b0;
    #1 check("w11_lat1_valid", 66'(e_out_valid), 66'(0));
    @(negedge clk);
    #1;
    check("w11_lat2_valid", 66'(e_out_valid), 66'(1));
    check("w11_s", 66'(e_s), 66'(11'h001));
    check("w11_cout", 66'(e_cout), 66'(1));
    check("w11_ovf", 66'(e_ovf), 66'(0));

    all_done = 1'b0;
    for (int t = 0; t < 60000 && !all_done; t++) begin
      @(negedge clk);
      all_done = g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done;
    end
    check("random_complete", 66'(all_done), 66'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, meaning operand and sum width in bits (legal 2..64).
REQ-002 The block SHALL provide parameter GROUP, default 4, meaning the lookahead group size in bits (legal 2..8); WIDTH need not be a multiple of GROUP, and the last group is partial.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  an operand set is presented.
REQ-006 in_ready  output  1  the block accepts the operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used when sub=0.
REQ-010 sub  input  1  0: compute a+b+cin; 1: compute a+~b+1 (two's-complement a-b; cin ignored).
REQ-011 out_valid  output  1  the result is valid.
REQ-012 out_ready  input  1  the downstream consumer accepts the result.
REQ-013 s  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of bit WIDTH-1 (for sub=1: 1 = no borrow).
REQ-015 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-016 Stage 1 SHALL register, per bit, p=a^b' and g=a&b' (b'=b^{WIDTH{sub}}), per-group generate/propagate, the effective carry-in (sub ? 1 : cin), and a valid bit.
REQ-017 Stage 2 SHALL compute the group carries by lookahead across groups from stage-1 registers, compute the intra-group carries by lookahead, and register s, cout, ovf, and out_valid.
REQ-018 Latency SHALL be exactly 2 cycles from handshake (in_valid&in_ready) to out_valid with out_ready continuously high; sustained throughput SHALL be 1 result/cycle.
REQ-019 A transfer in SHALL occur only on a cycle where in_valid&in_ready; a transfer out SHALL occur only on a cycle where out_valid&out_ready.
REQ-020 Stage 2 SHALL advance when !out_valid || out_ready; stage 1 SHALL advance when it is empty or stage 2 advances.
REQ-021 in_ready SHALL equal (!s1_valid || stage-2 advance), combinationally, and SHALL NOT depend on in_valid.
REQ-022 While out_valid=1 and out_ready=0, s, cout, ovf and out_valid SHALL hold stable, and no operand set SHALL be lost or duplicated.
REQ-023 With both stages full and the output stalled, in_ready SHALL be 0; at most 2 results SHALL be in flight.
REQ-024 Results SHALL leave in acceptance order.
REQ-025 The sum SHALL wrap modulo 2^WIDTH; there SHALL be no saturation.
REQ-026 For the partial last group, carry logic SHALL treat the missing bits as p=0, g=0 and SHALL take cout from bit WIDTH-1.
REQ-027 Every output SHALL be bit-exact with {cout,s} = a + (sub ? ~b+1 : b + cin) computed in WIDTH+1 bits (for sub=1, cout is bit WIDTH of a+~b+1).

Reset
REQ-028 While rst=1 at a clock edge, out_valid and both stage valid bits SHALL clear to 0, and s, cout and ovf SHALL clear to 0.
REQ-029 During and after reset, in_ready SHALL be 1 on the first cycle rst is low.
REQ-030 An operand set accepted on a cycle where rst=1 SHALL be discarded.
REQ-031 Operations in flight when rst asserts mid-operation SHALL be dropped with no out_valid pulse.

Verification
REQ-032 WIDTH=16, GROUP=4, a=0xFFFF, b=0x0001, cin=0, sub=0 -> 2 cycles later s=0x0000, cout=1, ovf=0.
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, cout=0, ovf=1; a=0x0005, b=0x0007, sub=1, cin=1 -> s=0xFFFE, cout=0, ovf=0.
REQ-034 Back-to-back stream of 4 ops with out_ready held 0 after the first result -> in_ready falls after 2 outstanding, out data is stable, release yields all 4 in order with no loss.
REQ-035 rst pulsed for 1 cycle with 2 ops in flight -> no out_valid afterwards until new input; in_ready=1 the cycle after rst.
REQ-036 WIDTH=11, GROUP=4 (partial group), a=0x7FF, b=0x001, cin=1 -> s=0x001, cout=1; plus 10k random ops per WIDTH in {2,11,16,33} -> match the REQ-027 reference model.
